// File: rtl/display_scan_ctrl_pkg.sv
// Shared state encoding, anode constant and width helper for the display scan controller.
package disp_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  // Widest supported display is 8 digits; callers slice to their digit count.
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Host/display-side bundle of the scan controller: host load channel plus digit drive outputs.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value_i;
  logic                    load_i;
  logic                    load_ack_o;
  logic [3:0]              number_o;
  logic [NUM_DIGITS-1:0]   anode_o;
  logic                    frame_o;

  modport master (
    output value_i, load_i,
    input  load_ack_o, number_o, anode_o, frame_o
  );

  modport slave (
    input  value_i, load_i,
    output load_ack_o, number_o, anode_o, frame_o
  );

endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// Per-state phase timer: counts 0..last, flags terminal count, restarts from 0 on clr.
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment digit scanner with frame-aligned double-buffered display value.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits, timing unchanged).
//
//   state   | meaning
//   S_BLANK | all anodes off for GUARD cycles, number_o already shows the next digit
//   S_DRIVE | anode of digit idx on for REFRESH_DIV cycles, then advance idx
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input logic                clk,
  input logic                reset_n,
  display_scan_ctrl_if.slave bus
);

  localparam int TMAX = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
  localparam int TW   = clog2(TMAX);
  localparam int IW   = clog2(NUM_DIGITS);
  localparam int VW   = 4 * NUM_DIGITS;
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] A_OFF    = ANODE_OFF[NUM_DIGITS-1:0];

  state_t                state, state_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [VW-1:0]         active, active_nx;
  logic [VW-1:0]         pending, pending_nx;
  logic                  pend_valid, pend_valid_nx;
  logic [NUM_DIGITS-1:0] anode_nx;
  logic [NUM_DIGITS-1:0] digit_on;
  logic [3:0]            number_nx;
  logic                  frame_nx, ack_nx;
  logic [TW-1:0]         t_last;
  logic                  t_clr, t_tc;

  assign t_last = (state == S_BLANK) ? TW'(GUARD - 1) : TW'(REFRESH_DIV - 1);
  assign t_clr  = (state_nx != state);

  scan_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (t_clr),
    .last    (t_last),
    .tc      (t_tc)
  );

  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    active_nx     = active;
    pending_nx    = pending;
    pend_valid_nx = pend_valid;
    frame_nx      = 1'b0;
    ack_nx        = 1'b0;
    case (state)
      S_BLANK: if (t_tc) state_nx = S_DRIVE;
      S_DRIVE: if (t_tc) begin
        state_nx = S_BLANK;
        if (idx == IDX_LAST) begin
          idx_nx   = '0;
          frame_nx = 1'b1;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      default: state_nx = S_BLANK;
    endcase
    // Commit uses the pending value from before this cycle's load, so a
    // same-cycle load stays pending for the following frame.
    if (frame_nx && pend_valid) begin
      active_nx     = pending;
      pend_valid_nx = 1'b0;
      ack_nx        = 1'b1;
    end
    if (bus.load_i) begin
      pending_nx    = bus.value_i;
      pend_valid_nx = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic nz_seen;

  always_comb begin
    nz_seen  = 1'b0;
    digit_on = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz_seen     = nz_seen | (active_nx[4*k +: 4] != 4'h0);
      digit_on[k] = nz_seen | (k == 0);
    end
  end
`else
  assign digit_on = '1;
`endif

  // Outputs are registered from next-state values so they line up with the state change.
  always_comb begin
    anode_nx = A_OFF;
    if (state_nx == S_DRIVE && digit_on[idx_nx]) anode_nx[idx_nx] = 1'b0;
    number_nx = active_nx[4*idx_nx +: 4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_BLANK;
      idx            <= '0;
      active         <= '0;
      pending        <= '0;
      pend_valid     <= 1'b0;
      bus.anode_o    <= A_OFF;
      bus.number_o   <= 4'h0;
      bus.frame_o    <= 1'b0;
      bus.load_ack_o <= 1'b0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      active         <= active_nx;
      pending        <= pending_nx;
      pend_valid     <= pend_valid_nx;
      bus.anode_o    <= anode_nx;
      bus.number_o   <= number_nx;
      bus.frame_o    <= frame_nx;
      bus.load_ack_o <= ack_nx;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: stimulus queues commits, a monitor checks every cycle.
`timescale 1ns/1ps
module tb_display_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int SLOT  = RD + GD;
  localparam int FRAME = ND * SLOT;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD       (GD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int          tcnt;
  logic [15:0] exp_q[$];
  logic [15:0] cur = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Reference anode pattern from cycles elapsed since reset release.
  function automatic logic [3:0] exp_anode(input int t, input logic [15:0] a);
    int p, d, w;
    logic [3:0] r;
    logic lz;
    p  = t % FRAME;
    d  = p / SLOT;
    w  = p % SLOT;
    r  = 4'hF;
    lz = (d > 0) && ((a >> (4 * d)) == 16'h0);
    if (w >= GD && !(LZB && lz)) r[d] = 1'b0;
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tcnt <= 0;
    else          tcnt <= tcnt + 1;
  end

  always @(negedge clk) begin : mon
    int   p, d;
    logic exp_ack;
    if (!reset_n) begin
      cur = 16'h0;
    end else begin
      p       = tcnt % FRAME;
      d       = p / SLOT;
      exp_ack = (p == 0) && (tcnt > 0) && (exp_q.size() > 0);
      chk("load_ack_o", bus.load_ack_o, exp_ack);
      if (exp_ack) cur = exp_q.pop_front();
      chk("frame_o", bus.frame_o, (p == 0) && (tcnt > 0));
      chk("anode_o", bus.anode_o, exp_anode(tcnt, cur));
      chk("number_o", bus.number_o, cur[4*d +: 4]);
    end
  end

  task automatic wait_p(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((tcnt % FRAME) != target && n < 2 * FRAME);
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.value_i = v;
    bus.load_i  = 1'b1;
    @(negedge clk);
    bus.load_i  = 1'b0;
  endtask

  initial begin
    bus.value_i = 16'h0;
    bus.load_i  = 1'b0;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_anode", bus.anode_o, 4'hF);
    chk("rst_number", bus.number_o, 4'h0);
    chk("rst_ack", bus.load_ack_o, 1'b0);
    chk("rst_frame", bus.frame_o, 1'b0);
    reset_n = 1'b1;

    // Idle scan, nothing loaded.
    repeat (2 * FRAME + 5) @(negedge clk);

    // Single mid-frame load.
    wait_p(15);
    exp_q.push_back(16'h4321);
    do_load(16'h4321);
    repeat (2 * FRAME) @(negedge clk);

    // Two loads in one frame: last write wins, single ack.
    wait_p(5);
    do_load(16'h1111);
    wait_p(20);
    exp_q.push_back(16'h2222);
    do_load(16'h2222);
    repeat (2 * FRAME) @(negedge clk);

    // Load landing on the commit edge while another value is pending.
    wait_p(10);
    exp_q.push_back(16'h9999);
    do_load(16'h9999);
    wait_p(FRAME - 1);
    exp_q.push_back(16'h5555);
    do_load(16'h5555);
    repeat (2 * FRAME + 5) @(negedge clk);

    // Reset during the DRIVE slot of digit 2.
    wait_p(2 * SLOT + 5);
    reset_n = 1'b0;
    #1;
    chk("midrst_anode", bus.anode_o, 4'hF);
    chk("midrst_number", bus.number_o, 4'h0);
    chk("midrst_ack", bus.load_ack_o, 1'b0);
    chk("midrst_frame", bus.frame_o, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (FRAME + 5) @(negedge clk);

    // Leading-zero patterns and hex nibbles above 9.
    wait_p(8);
    exp_q.push_back(16'h0070);
    do_load(16'h0070);
    repeat (2 * FRAME) @(negedge clk);
    wait_p(8);
    exp_q.push_back(16'h0000);
    do_load(16'h0000);
    repeat (2 * FRAME) @(negedge clk);
    wait_p(30);
    exp_q.push_back(16'hABCF);
    do_load(16'hABCF);
    repeat (2 * FRAME) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
